// File: rtl/ip2_scan_seq.sv
`timescale 1ns/1ps
// ip2_scan_seq
// -------------
// Sequencer for one scan test. A test runs in this order:
//   DELAY  : the external scan-data registers reload.
//   RESET  : the device under test is held in reset. o_reset_not can be masked.
//   LOAD1  : the comparators load and o_trig_out rises.
//   LOAD2  : o_trig_out falls.
//   SHIFT  : CHAIN_LEN bits are shifted.
//   NEXT   : the next pass is prepared.
//   DONE   : the test is complete.
// All transitions happen on a "tick", which is the cycle where clk_counter == test_delay.
// The exceptions are start, abort, enable and DONE->IDLE.
// In mode 1 the sequencer skips RESET/LOAD1/LOAD2 and only shifts.
//
// Handshake: start acts as a one-cycle valid. It is accepted only in IDLE
// (o_busy == 0) and only while abort is low. A start in any other condition
// is dropped. There is no backpressure.
//
// Ports
//   clk, reset_not          : clock, async active-low reset
//   enable                  : low = synchronous return to IDLE (o_done/o_aborted hold)
//   clk_counter[5:0]        : free-running phase counter
//   test_delay[5:0]         : tick phase
//   test_trig_out_phase[5:0]: phase at which o_trig_out toggles in LOAD1/LOAD2
//   test_mask_reset_not     : 1 = keep o_reset_not high during RESET
//   start, abort            : launch pulse / terminate level
//   mode, n_passes[3:0]     : test configuration, sampled on an accepted start
//   scan_bit[N_CHAINS-1:0]  : bit0 of each external scan-data register
//   o_scan_in, o_scan_load, o_reset_not, o_trig_out : scan-chain controls
//   o_reg_load, o_reg_shift : external data-register controls
//   o_busy, o_done, o_aborted, o_pass_cnt[3:0], o_state[2:0] : status / debug
module ip2_scan_seq #(
   parameter int N_CHAINS  = 1,
   parameter int CHAIN_LEN = 768,
   parameter int CNT_W     = 11
) (
   input  logic                clk,
   input  logic                reset_not,
   input  logic                enable,
   input  logic [5:0]          clk_counter,
   input  logic [5:0]          test_delay,
   input  logic [5:0]          test_trig_out_phase,
   input  logic                test_mask_reset_not,
   input  logic                start,
   input  logic                abort,
   input  logic                mode,
   input  logic [3:0]          n_passes,
   input  logic [N_CHAINS-1:0] scan_bit,
   output logic [N_CHAINS-1:0] o_scan_in,
   output logic                o_scan_load,
   output logic                o_reset_not,
   output logic                o_trig_out,
   output logic                o_reg_load,
   output logic                o_reg_shift,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_aborted,
   output logic [3:0]          o_pass_cnt,
   output logic [2:0]          o_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DELAY = 3'd1,
      S_RESET = 3'd2,
      S_LOAD1 = 3'd3,
      S_LOAD2 = 3'd4,
      S_SHIFT = 3'd5,
      S_NEXT  = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mode_q, mode_d;
   logic [3:0]          npass_q, npass_d;
   logic [3:0]          pass_cnt_q, pass_cnt_d;
   logic [N_CHAINS-1:0] scan_in_q, scan_in_d;
   logic                scan_load_q, scan_load_d;
   logic                reset_out_q, reset_out_d;
   logic                trig_q, trig_d;
   logic                reg_load_q, reg_load_d;
   logic                reg_shift_q, reg_shift_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;

   logic       tick;
   logic [5:0] shift_phase;
   logic       last_bit;
   logic       more_passes;

   assign tick        = (clk_counter == test_delay);
   // The external register shifts two cycles ahead of the tick.
   // This gives the new bit time to settle before it is sampled.
   // The 6-bit subtraction wraps modulo 64 by construction.
   assign shift_phase = test_delay - 6'd2;
   assign last_bit    = (cnt_q == CNT_W'(CHAIN_LEN - 1));
   assign more_passes = (({1'b0, pass_cnt_q} + 5'd1) < {1'b0, npass_q});

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      npass_d    = npass_q;
      pass_cnt_d = pass_cnt_q;
      scan_in_d  = scan_in_q;
      trig_d     = trig_q;
      done_d     = done_q;
      aborted_d  = aborted_q;

      if (!enable) begin
         state_d = S_IDLE;
      end else if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         aborted_d = 1'b1;
         done_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_d   = S_DELAY;
                  mode_d    = mode;
                  npass_d   = (n_passes == 4'd0) ? 4'd1 : n_passes;
                  done_d    = 1'b0;
                  aborted_d = 1'b0;
               end
            end
            S_DELAY: if (tick) state_d = mode_q ? S_SHIFT : S_RESET;
            S_RESET: if (tick) state_d = S_LOAD1;
            S_LOAD1: begin
               if (clk_counter == test_trig_out_phase) trig_d = 1'b1;
               if (tick) state_d = S_LOAD2;
            end
            S_LOAD2: begin
               if (clk_counter == test_trig_out_phase) trig_d = 1'b0;
               if (tick) state_d = S_SHIFT;
            end
            S_SHIFT: begin
               scan_in_d = scan_bit;
               if (tick) begin
                  if (last_bit) begin
                     cnt_d = '0;
                     if (more_passes) begin
                        state_d = S_NEXT;
                     end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            S_NEXT: begin
               if (tick) begin
                  pass_cnt_d = pass_cnt_q + 4'd1;
                  state_d    = mode_q ? S_SHIFT : S_LOAD1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // Every path into IDLE restores the idle output values.
      if (state_d == S_IDLE) begin
         cnt_d      = '0;
         pass_cnt_d = 4'd0;
         scan_in_d  = '0;
         trig_d     = 1'b0;
      end

      // Output registers follow the state being entered.
      // Each update therefore lands on the same edge as the transition.
      scan_load_d = !((state_d == S_RESET) || (state_d == S_SHIFT));
      reset_out_d = (state_d == S_RESET) ? test_mask_reset_not : 1'b1;
      reg_load_d  = (state_d == S_DELAY) ||
                    ((state_d == S_NEXT) && (state_q != S_NEXT));
      reg_shift_d = (state_q == S_SHIFT) && (state_d == S_SHIFT) &&
                    (clk_counter == shift_phase);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_not) begin
      if (!reset_not) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         npass_q     <= 4'd1;
         pass_cnt_q  <= 4'd0;
         scan_in_q   <= '0;
         scan_load_q <= 1'b1;
         reset_out_q <= 1'b1;
         trig_q      <= 1'b0;
         reg_load_q  <= 1'b0;
         reg_shift_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         npass_q     <= npass_d;
         pass_cnt_q  <= pass_cnt_d;
         scan_in_q   <= scan_in_d;
         scan_load_q <= scan_load_d;
         reset_out_q <= reset_out_d;
         trig_q      <= trig_d;
         reg_load_q  <= reg_load_d;
         reg_shift_q <= reg_shift_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

   assign o_scan_in   = scan_in_q;
   assign o_scan_load = scan_load_q;
   assign o_reset_not = reset_out_q;
   assign o_trig_out  = trig_q;
   assign o_reg_load  = reg_load_q;
   assign o_reg_shift = reg_shift_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_aborted   = aborted_q;
   assign o_pass_cnt  = pass_cnt_q;
   assign o_state     = state_q;

endmodule
